// File: rtl/cb_cfg_pkg.sv
// Shared types and default parameters for the connection-block config loader.
package cb_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CSUM    = 2'd2,
        ST_ISOLATE = 2'd3
    } cb_cfg_state_t;

    localparam int CB_CFG_NUM_BITS   = 112;
    localparam int CB_CFG_WORD_W     = 8;
    localparam int CB_CFG_ISO_CYCLES = 2;
    localparam int CB_CFG_NUM_WORDS  = CB_CFG_NUM_BITS / CB_CFG_WORD_W;

endpackage

// File: rtl/cb_cfg_csum.sv
// Modulo-2^WORD_W running checksum with a look-ahead zero check on the
// byte currently presented, so the final checksum byte needs no extra cycle.
module cb_cfg_csum
    import cb_cfg_pkg::*;
#(
    parameter int WORD_W = CB_CFG_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              zero_o
);

    logic [WORD_W-1:0] sum_q, sum_d;
    logic [WORD_W-1:0] sum_peek;

    // Next sum: clear takes priority over accumulate.
    always_comb begin
        sum_d = sum_q;
        if (clr_i)
            sum_d = '0;
        else if (add_i)
            sum_d = sum_q + data_i;
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign sum_peek = sum_q + data_i;
    assign zero_o   = (sum_peek == '0);

endmodule

// File: rtl/cb_config_loader.sv
// Byte-serial loader for the connection-block latch bits: shadows the stream,
// checks the checksum, opens all gates for a guard interval, then commits.
module cb_config_loader
    import cb_cfg_pkg::*;
#(
    parameter int NUM_BITS   = CB_CFG_NUM_BITS,
    parameter int WORD_W     = CB_CFG_WORD_W,
    parameter int ISO_CYCLES = CB_CFG_ISO_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [NUM_BITS-1:0] sram_latch_con_bits,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int NUM_WORDS = NUM_BITS / WORD_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int GRD_W     = (ISO_CYCLES > 1) ? $clog2(ISO_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    cb_cfg_state_t       state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GRD_W-1:0]    guard_q, guard_d;
    logic [NUM_BITS-1:0] shadow_q, shadow_d;
    logic [NUM_BITS-1:0] bus_q, bus_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                sum_clr, sum_add, sum_zero;
    logic                xfer;

    // Abort masks ready so an aborted cycle never consumes a byte.
    assign cfg_ready = ((state_q == ST_LOAD) || (state_q == ST_CSUM)) && !cfg_abort;
    assign xfer      = cfg_valid && cfg_ready;

    cb_cfg_csum #(.WORD_W(WORD_W)) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sum_clr),
        .add_i  (sum_add),
        .data_i (cfg_data),
        .zero_o (sum_zero)
    );

    // Next-state logic; the live bus only ever goes to all-0 or the full shadow.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        guard_d  = guard_q;
        shadow_d = shadow_q;
        bus_d    = bus_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        sum_clr  = 1'b0;
        sum_add  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    sum_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    shadow_d[idx_q*WORD_W +: WORD_W] = cfg_data;
                    sum_add = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX)
                        state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    if (sum_zero) begin
                        state_d = ST_ISOLATE;
                        bus_d   = '0;
                        guard_d = GRD_W'(ISO_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ISOLATE: begin
                // Start/abort deliberately ignored: always run to commit.
                if (guard_q == '0) begin
                    bus_d   = shadow_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset to all gates open.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            guard_q  <= '0;
            shadow_q <= '0;
            bus_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            guard_q  <= guard_d;
            shadow_q <= shadow_d;
            bus_q    <= bus_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign sram_latch_con_bits = bus_q;
    assign busy                = (state_q != ST_IDLE);
    assign done                = done_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_cb_config_loader.sv
// Scoreboard bench: each load pushes its expected done/err outcome; a monitor
// pops and checks whenever the loader pulses done or err.
module tb_cb_config_loader;

    localparam int NB  = 112;
    localparam int WW  = 8;
    localparam int ISO = 2;
    localparam int NW  = NB / WW;

    typedef logic [7:0] pat_t [NW];
    typedef struct {
        bit          is_done;
        logic [NB-1:0] bus;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [WW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [NB-1:0] sram_latch_con_bits;
    logic          busy, done, err;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];
    logic [NB-1:0] exp_bus = '0;
    pat_t p1, p2, p3;

    cb_config_loader #(.NUM_BITS(NB), .WORD_W(WW), .ISO_CYCLES(ISO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_start           (cfg_start),
        .cfg_abort           (cfg_abort),
        .cfg_data            (cfg_data),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .sram_latch_con_bits (sram_latch_con_bits),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [NB-1:0] pack(input pat_t b);
        logic [NB-1:0] v = '0;
        for (int k = 0; k < NW; k++) v[k*8 +: 8] = b[k];
        return v;
    endfunction

    function automatic logic [7:0] good_cs(input pat_t b);
        logic [7:0] s = 8'h00;
        for (int k = 0; k < NW; k++) s = s + b[k];
        return 8'h00 - s;
    endfunction

    // Monitor: every done/err pulse must match the oldest expected outcome.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done || err) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse", done, err);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_done", {127'b0, done}, {127'b0, e.is_done});
                    chk("sb_err",  {127'b0, err},  {127'b0, !e.is_done});
                    chk("sb_bus",  128'(sram_latch_con_bits), 128'(e.bus));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] d, input bit gaps);
        bit acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                cfg_valid = 1'b0;
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = d;
                #1 acc = cfg_ready;
            end
        end
        if (!acc) begin
            n_vec++; n_miss++;
            $display("FAIL byte_timeout: got ready=0 expected ready=1");
        end
    endtask

    task automatic start_load(input bit pre);
        if (!pre) begin
            @(negedge clk);
            cfg_start = 1'b1;
        end
        // Stray byte in the start cycle must not be consumed.
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("start_busy", {127'b0, busy}, 128'd1);
    endtask

    task automatic load(input pat_t b, input logic [7:0] cs, input bit gaps, input bit pre,
                        input bit poke, input bit rst_iso, input bit chain);
        logic [NB-1:0] nb;
        logic [7:0]    s;
        bit            good;
        nb = pack(b);
        s  = cs;
        for (int k = 0; k < NW; k++) s = s + b[k];
        good = (s == 8'h00);
        start_load(pre);
        for (int k = 0; k < NW; k++) send_byte(b[k], gaps);
        if (good && !rst_iso) sb_q.push_back('{1'b1, nb});
        else if (!good)       sb_q.push_back('{1'b0, exp_bus});
        send_byte(cs, 1'b0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (!good) begin
            chk("bad_err",  {127'b0, err}, 128'd1);
            chk("bad_busy", {127'b0, busy}, 128'd0);
            chk("bad_bus",  128'(sram_latch_con_bits), 128'(exp_bus));
            return;
        end
        chk("iso0_bus",  128'(sram_latch_con_bits), 128'd0);
        chk("iso0_busy", {127'b0, busy}, 128'd1);
        if (poke) begin
            cfg_start = 1'b1;
            cfg_abort = 1'b1;
        end
        if (rst_iso) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            cfg_start = 1'b0;
            cfg_abort = 1'b0;
            chk("rstiso_bus",  128'(sram_latch_con_bits), 128'd0);
            chk("rstiso_busy", {127'b0, busy}, 128'd0);
            exp_bus = '0;
            return;
        end
        for (int i = 1; i < ISO; i++) begin
            @(posedge clk); #1;
            cfg_start = 1'b0;
            cfg_abort = 1'b0;
            chk("iso_bus",  128'(sram_latch_con_bits), 128'd0);
            chk("iso_busy", {127'b0, busy}, 128'd1);
        end
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        chk("commit_done", {127'b0, done}, 128'd1);
        chk("commit_busy", {127'b0, busy}, 128'd0);
        chk("commit_bus",  128'(sram_latch_con_bits), 128'(nb));
        exp_bus = nb;
        if (chain) cfg_start = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NW; k++) begin
            p1[k] = 8'(k + 1);
            p2[k] = 8'hF0 ^ 8'(k * 17);
            p3[k] = 8'h3C + 8'(k * k);
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_bus",   128'(sram_latch_con_bits), 128'd0);
        chk("rst_ready", {127'b0, cfg_ready}, 128'd0);
        chk("rst_busy",  {127'b0, busy}, 128'd0);
        chk("rst_done",  {127'b0, done}, 128'd0);
        chk("rst_err",   {127'b0, err}, 128'd0);

        // Valid pulses in IDLE do nothing
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_data  = 8'(8'hA5 + i);
            #1 chk("idle_ready", {127'b0, cfg_ready}, 128'd0);
            @(negedge clk);
            cfg_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("idle_busy", {127'b0, busy}, 128'd0);
        chk("idle_bus",  128'(sram_latch_con_bits), 128'd0);

        // Good load: 1..14 with hand-computed checksum 0x97
        load(p1, 8'h97, 0, 0, 0, 0, 0);
        chk("p1_low_byte", 128'(sram_latch_con_bits[7:0]), 128'h01);
        chk("p1_top_byte", 128'(sram_latch_con_bits[111:104]), 128'h0E);

        // Bad checksum leaves pattern A in place
        load(p2, good_cs(p2) + 8'h01, 0, 0, 0, 0, 0);

        // Gapped valid still commits
        load(p2, good_cs(p2), 1, 0, 0, 0, 0);

        // Abort after byte 5 with valid high
        start_load(0);
        for (int k = 0; k < 5; k++) send_byte(p3[k], 0);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = 8'h55;
        cfg_abort = 1'b1;
        #1 chk("abort_ready", {127'b0, cfg_ready}, 128'd0);
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        chk("abort_busy", {127'b0, busy}, 128'd0);
        chk("abort_bus",  128'(sram_latch_con_bits), 128'(exp_bus));

        // Full load after abort, with start/abort poked in ISOLATE and a chained start
        load(p3, good_cs(p3), 0, 0, 1, 0, 1);
        load(p1, 8'h97, 0, 1, 0, 0, 0);

        // Reset after byte 9
        start_load(0);
        for (int k = 0; k < 9; k++) send_byte(p2[k], 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstload_bus",  128'(sram_latch_con_bits), 128'd0);
        chk("rstload_busy", {127'b0, busy}, 128'd0);
        exp_bus = '0;
        load(p3, good_cs(p3), 0, 0, 0, 0, 0);

        // Reset mid-ISOLATE, then a clean load
        load(p2, good_cs(p2), 0, 0, 0, 1, 0);
        load(p1, 8'h97, 1, 0, 0, 0, 0);

        repeat (5) @(posedge clk);
        #1 chk("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
